finite_inv: RTL and testbench

Inverse and stream checker for the mod-100 incrementing device. Each valid 7-bit sample from that device, a value v, is taken as the device's output. The block returns the device's input, (v + 99) mod 100, one cycle later. It also tracks the sample stream, counts wrap-arounds from 99 to 0, and flags samples that break the +1 mod 100 sequence. It sits directly downstream of the incrementer in the regression harness and closes the loop back to the original stimulus.

---
 rtl/finite_inv.sv | 87 ++++++++
 tb/tb_finite_inv.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/finite_inv.sv
// finite_inv: inverse of the mod-MODULUS incrementer with an optional stream checker.
// Define FINITE_INV_CHECK_EN to build the sequence checker and wrap counter.
module finite_inv #(
  parameter int MODULUS = 100,
  parameter int W       = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W:0]     __in0,
  output logic [2*W+1:0] __out0
);

  localparam logic [2*W:0] MOD_W = (2*W+1)'(MODULUS);
  localparam logic [2*W:0] ONE_W = (2*W+1)'(1);

  logic         in_valid;
  logic [W-1:0] in_value;
  logic [2*W:0] in_wide;
  logic [2*W:0] pred_sum;
  logic [W-1:0] pred_next;

  logic         out_valid;
  logic [W-1:0] pred;
  logic         seq_err;
  logic [W-1:0] wrap_cnt;

  assign in_valid  = __in0[W];
  assign in_value  = __in0[W-1:0];
  assign in_wide   = {{(W+1){1'b0}}, in_value};
  // Wide sum keeps illegal inputs (>= MODULUS) from overflowing before the reduction.
  assign pred_sum  = in_wide + MOD_W - ONE_W;
  assign pred_next = W'(pred_sum % MOD_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      pred      <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) pred <= pred_next;
    end
  end

`ifdef FINITE_INV_CHECK_EN
  // state | meaning
  // IDLE  | no previous sample held since reset
  // TRACK | prev holds the last valid sample
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  logic [0:0]   tag;
  logic [W-1:0] prev;
  logic [2*W:0] expected;
  logic         illegal;
  logic         mismatch;
  logic         wrap_hit;

  assign expected = ({{(W+1){1'b0}}, prev} + ONE_W) % MOD_W;
  assign illegal  = (in_wide >= MOD_W);
  assign mismatch = (in_wide != expected);
  assign wrap_hit = (prev == W'(MODULUS - 1)) && (in_value == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag      <= IDLE;
      prev     <= '0;
      seq_err  <= 1'b0;
      wrap_cnt <= '0;
    end else if (in_valid) begin
      prev <= in_value;
      if (tag == IDLE) begin
        tag <= TRACK;
        if (illegal) seq_err <= 1'b1;
      end else begin
        if (mismatch || illegal) seq_err <= 1'b1;
        if (wrap_hit) wrap_cnt <= wrap_cnt + 1'b1;
      end
    end
  end
`else
  assign seq_err  = 1'b0;
  assign wrap_cnt = '0;
`endif

  assign __out0 = {out_valid, seq_err, wrap_cnt, pred};

endmodule

// File: tb/tb_finite_inv.sv
// Directed self-checking bench for finite_inv; expectations follow FINITE_INV_CHECK_EN.
module tb_finite_inv;

  localparam int W = 7;
`ifdef FINITE_INV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [W:0]     in0;
  logic [2*W+1:0] out0;
  logic [2*W+1:0] exp_v;

  int vectors;
  int miscompares;

  finite_inv #(.MODULUS(100), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .__in0 (in0),
    .__out0(out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W+1:0] mk(input bit ov, input bit err, input int wrap, input int pred);
    logic [W-1:0] w7;
    logic [W-1:0] p7;
    w7 = W'(wrap);
    p7 = W'(pred);
    return {ov, err & CHK, CHK ? w7 : 7'd0, p7};
  endfunction

  // Drive one cycle of input, then sample just after the capturing edge.
  task automatic drive(input bit valid, input int value);
    @(negedge clk);
    in0 = {valid, W'(value)};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in0 = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in0 = '0;
    repeat (2) @(negedge clk);
    exp_v = mk(0, 0, 0, 0);
    vectors++;
    if (out0 !== exp_v) begin
      $display("FAIL reset: got %h want %h", out0, exp_v);
      miscompares++;
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int ins[3]  = '{5, 6, 7};
    int pred[3] = '{4, 5, 6};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, ins[i]);
      exp_v = mk(1, 0, 0, pred[i]);
      vectors++;
      if (out0 !== exp_v) begin
        $display("FAIL basic[%0d]: got %h want %h", i, out0, exp_v);
        miscompares++;
      end
    end
  endtask

  task automatic test_wrap();
    int ins[4]  = '{98, 99, 0, 1};
    int pred[4] = '{97, 98, 99, 0};
    int wrap[4] = '{0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, ins[i]);
      exp_v = mk(1, 0, wrap[i], pred[i]);
      vectors++;
      if (out0 !== exp_v) begin
        $display("FAIL wrap[%0d]: got %h want %h", i, out0, exp_v);
        miscompares++;
      end
    end
  endtask

  task automatic test_seq_err();
    int ins[4]  = '{10, 11, 13, 14};
    int pred[4] = '{9, 10, 12, 13};
    bit err[4]  = '{0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, ins[i]);
      exp_v = mk(1, err[i], 0, pred[i]);
      vectors++;
      if (out0 !== exp_v) begin
        $display("FAIL seq_err[%0d]: got %h want %h", i, out0, exp_v);
        miscompares++;
      end
    end
  endtask

  task automatic test_first_sample();
    do_reset();
    drive(1, 120);
    exp_v = mk(1, 1, 0, 19);
    vectors++;
    if (out0 !== exp_v) begin
      $display("FAIL illegal_first: got %h want %h", out0, exp_v);
      miscompares++;
    end
    do_reset();
    drive(1, 0);
    exp_v = mk(1, 0, 0, 99);
    vectors++;
    if (out0 !== exp_v) begin
      $display("FAIL zero_first: got %h want %h", out0, exp_v);
      miscompares++;
    end
  endtask

  task automatic test_gap();
    do_reset();
    drive(1, 50);
    exp_v = mk(1, 0, 0, 49);
    vectors++;
    if (out0 !== exp_v) begin
      $display("FAIL gap_first: got %h want %h", out0, exp_v);
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 77);
      exp_v = mk(0, 0, 0, 49);
      vectors++;
      if (out0 !== exp_v) begin
        $display("FAIL gap_idle[%0d]: got %h want %h", i, out0, exp_v);
        miscompares++;
      end
    end
    drive(1, 51);
    exp_v = mk(1, 0, 0, 50);
    vectors++;
    if (out0 !== exp_v) begin
      $display("FAIL gap_resume: got %h want %h", out0, exp_v);
      miscompares++;
    end
  endtask

  // Alternating 99,0 pairs: every 0 wraps, every 99 after the first breaks sequence.
  task automatic test_wrap_rollover();
    do_reset();
    for (int k = 1; k <= 128; k++) begin
      drive(1, 99);
      drive(1, 0);
      if (k == 1 || k == 127 || k == 128) begin
        exp_v = mk(1, k >= 2, k % 128, 99);
        vectors++;
        if (out0 !== exp_v) begin
          $display("FAIL rollover[%0d]: got %h want %h", k, out0, exp_v);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 99);
      drive(1, 0);
    end
    exp_v = mk(1, 1, 3, 99);
    vectors++;
    if (out0 !== exp_v) begin
      $display("FAIL pre_reset: got %h want %h", out0, exp_v);
      miscompares++;
    end
    @(negedge clk);
    in0 = {1'b1, 7'd1};
    #2;
    rst = 1'b1;
    #1;
    exp_v = mk(0, 0, 0, 0);
    vectors++;
    if (out0 !== exp_v) begin
      $display("FAIL async_reset: got %h want %h", out0, exp_v);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1, 7);
    exp_v = mk(1, 0, 0, 6);
    vectors++;
    if (out0 !== exp_v) begin
      $display("FAIL post_reset: got %h want %h", out0, exp_v);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_seq_err();
    test_first_sample();
    test_gap();
    test_wrap_rollover();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
